multicycle_ctrl_fsm: RTL and testbench

Main control state machine for the multicycle 12-bit ARM core. It sequences fetch, decode, memory and ALU phases over several cycles per instruction. It drives the datapath mux selects and the unconditional write requests (PCS/RegisterW/MemoryW style), which the condition logic then gates with CondEx. It also provides a retired-instruction counter and an illegal-opcode pulse.

---
 rtl/multicycle_ctrl_fsm_if.sv | 44 ++++
 rtl/multicycle_ctrl_fsm.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-bus bundle between the multicycle control FSM and the datapath.
// The mem_ready line exists only when MEM_HANDSHAKE_EN is defined.
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       op;
  logic             funct_i;
  logic             funct_l;
`ifdef MEM_HANDSHAKE_EN
  logic             mem_ready;
`endif
  logic             ir_write;
  logic             next_pc;
  logic             reg_w;
  logic             mem_w;
  logic             branch;
  logic             alu_op;
  logic             adr_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       result_src;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  // The FSM side drives the control outputs and reads the instruction fields.
  modport master (
`ifdef MEM_HANDSHAKE_EN
    input  mem_ready,
`endif
    input  op, funct_i, funct_l,
    output ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
    output alu_src_a, alu_src_b, result_src, illegal, instr_count, state
  );

  modport slave (
`ifdef MEM_HANDSHAKE_EN
    output mem_ready,
`endif
    output op, funct_i, funct_l,
    input  ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
    input  alu_src_a, alu_src_b, result_src, illegal, instr_count, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle 12-bit ARM core: fetch/decode/memory/ALU sequencing.
// Optional MEM_HANDSHAKE_EN: FETCH, MEMREAD and MEMWRITE stall until bus.mem_ready is 1.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 16
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [3:0] START    = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] MEMADR   = 4'd3;
  localparam logic [3:0] MEMREAD  = 4'd4;
  localparam logic [3:0] MEMWB    = 4'd5;
  localparam logic [3:0] MEMWRITE = 4'd6;
  localparam logic [3:0] EXECUTER = 4'd7;
  localparam logic [3:0] EXECUTEI = 4'd8;
  localparam logic [3:0] ALUWB    = 4'd9;
  localparam logic [3:0] BRANCH   = 4'd10;

  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] count_q;
  logic             mem_rdy;
  logic             retire;

`ifdef MEM_HANDSHAKE_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      START:    state_d = FETCH;
      FETCH:    if (mem_rdy) state_d = DECODE;
      DECODE: begin
        case (bus.op)
          2'b00:   state_d = bus.funct_i ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = bus.funct_l ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_rdy) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_rdy) state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its terminal state; a stalled
  // MEMWRITE has not left yet, so it must wait for mem_rdy.
  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                  ((state_q == MEMWRITE) && mem_rdy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= START;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  // Write strobes that touch memory or the IR are qualified by mem_rdy so a stalled
  // access produces exactly one strobe cycle; mux selects stay put during the stall.
  always_comb begin
    bus.ir_write   = 1'b0;
    bus.next_pc    = 1'b0;
    bus.reg_w      = 1'b0;
    bus.mem_w      = 1'b0;
    bus.branch     = 1'b0;
    bus.alu_op     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    case (state_q)
      FETCH: begin
        bus.ir_write   = mem_rdy;
        bus.next_pc    = mem_rdy;
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      DECODE: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
      end
      MEMADR: begin
        bus.alu_src_b  = 2'b01;
      end
      MEMREAD: begin
        bus.adr_src    = 1'b1;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src    = 1'b1;
        bus.mem_w      = mem_rdy;
      end
      EXECUTER: begin
        bus.alu_op     = 1'b1;
      end
      EXECUTEI: begin
        bus.alu_src_b  = 2'b01;
        bus.alu_op     = 1'b1;
      end
      ALUWB: begin
        bus.reg_w      = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_b  = 2'b01;
        bus.result_src = 2'b10;
        bus.branch     = 1'b1;
      end
      default: begin
        bus.reg_w      = 1'b0;
      end
    endcase
  end

  assign bus.illegal     = (state_q == DECODE) && (bus.op == 2'b11);
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: random instruction streams vs. a per-instruction model.
// Two instances run in lockstep: default counter width and a 2-bit counter for wrap checks.
module tb_multicycle_ctrl_fsm;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cnt   = 0;
  int   trace[$];
  logic [34:0] obs_q[$];
  logic [34:0] exp_q[$];

  multicycle_ctrl_fsm_if #(.CNT_W(16)) bus_a ();
  multicycle_ctrl_fsm_if #(.CNT_W(2))  bus_b ();

  multicycle_ctrl_fsm #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus_a));
  multicycle_ctrl_fsm #(.CNT_W(2))  dut_w (.clk(clk), .reset(reset), .bus(bus_b));

  assign bus_b.op      = bus_a.op;
  assign bus_b.funct_i = bus_a.funct_i;
  assign bus_b.funct_l = bus_a.funct_l;
`ifdef MEM_HANDSHAKE_EN
  assign bus_b.mem_ready = bus_a.mem_ready;
`endif

  always #5 clk = ~clk;

  logic [11:0] outs;
  logic [34:0] snap;
  assign outs = {bus_a.ir_write, bus_a.next_pc, bus_a.reg_w, bus_a.mem_w, bus_a.branch,
                 bus_a.alu_op, bus_a.adr_src, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.result_src};
  assign snap = {bus_a.state, outs, bus_a.illegal, bus_a.instr_count, bus_b.instr_count};

  // Output table per state code, in the same bit order as outs.
  function automatic logic [11:0] exp_out(input int s);
    case (s)
      1:       return 12'b1100_0001_1010;
      2:       return 12'b0000_0001_1010;
      3:       return 12'b0000_0000_0100;
      4:       return 12'b0000_0010_0000;
      5:       return 12'b0010_0000_0001;
      6:       return 12'b0001_0010_0000;
      7:       return 12'b0000_0100_0000;
      8:       return 12'b0000_0100_0100;
      9:       return 12'b0010_0000_0000;
      10:      return 12'b0000_1000_0110;
      default: return 12'b0;
    endcase
  endfunction

  // Runs one instruction from FETCH, recording observed and predicted snapshots per cycle.
  task automatic run_instr(input logic [1:0] op, input logic fi, input logic fl, input int stop);
    trace = {1, 2};
    case (op)
      2'b01:   if (fl) trace = {1, 2, 3, 4, 5}; else trace = {1, 2, 3, 6};
      2'b00:   if (fi) trace = {1, 2, 8, 9}; else trace = {1, 2, 7, 9};
      2'b10:   trace = {1, 2, 10};
      default: trace = {1, 2};
    endcase
    for (int i = 0; i < trace.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus_a.op      = (trace[i] == 2) ? op : 2'($urandom);
      bus_a.funct_i = (trace[i] == 2) ? fi : 1'($urandom);
      bus_a.funct_l = (trace[i] == 3) ? fl : 1'($urandom);
      #1;
      obs_q.push_back(snap);
      exp_q.push_back({4'(trace[i]), exp_out(trace[i]), (trace[i] == 2) && (op == 2'b11),
                       16'(cnt), 2'(cnt)});
      if (trace[i] == stop) return;
    end
    if (op != 2'b11) cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus_a.state !== 4'd0 || outs !== 12'd0) begin
      bad++;
      $display("[TB] FAIL start_hold got state=%0d outs=%h want state=0 outs=000", bus_a.state, outs);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus_a.state !== 4'd1 || bus_a.ir_write !== 1'b1 || bus_a.next_pc !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_fetch got state=%0d ir_write=%b next_pc=%b want 1/1/1",
               bus_a.state, bus_a.ir_write, bus_a.next_pc);
    end
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus_a.state, outs, bus_a.illegal, bus_a.instr_count} !== 33'd0) begin
        bad++;
        $display("[TB] FAIL reset_state got state=%0d outs=%h ill=%b cnt=%0d want all 0",
                 bus_a.state, outs, bus_a.illegal, bus_a.instr_count);
      end
    end
    release_reset();
    cnt = 0;
  endtask

  task automatic test_ldr_str_dp();
    run_instr(2'b01, 1'b0, 1'b1, -1);
    total++;
    if (bus_a.instr_count !== 16'd1) begin
      bad++;
      $display("[TB] FAIL ldr_count got=%0d want=1", bus_a.instr_count);
    end
    run_instr(2'b01, 1'b1, 1'b0, -1);
    run_instr(2'b00, 1'b1, 1'b0, -1);
    run_instr(2'b00, 1'b0, 1'b1, -1);
    total++;
    if (bus_a.instr_count !== 16'd4) begin
      bad++;
      $display("[TB] FAIL str_dp_count got=%0d want=4", bus_a.instr_count);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL ldr_str_dp cycle%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_branch_illegal();
    run_instr(2'b10, 1'b0, 1'b0, -1);
    run_instr(2'b11, 1'b1, 1'b1, -1);
    total++;
    if (bus_a.instr_count !== 16'd5 || bus_a.state !== 4'd1) begin
      bad++;
      $display("[TB] FAIL illegal_no_retire got cnt=%0d state=%0d want cnt=5 state=1",
               bus_a.instr_count, bus_a.state);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL branch_illegal cycle%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_mid_reset_wrap();
    run_instr(2'b00, 1'b0, 1'b0, 9);
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (bus_a.state !== 4'd0 || bus_a.reg_w !== 1'b0 || outs !== 12'd0 ||
        bus_a.instr_count !== 16'd0 || bus_b.instr_count !== 2'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset got state=%0d reg_w=%b cnt=%0d cntw=%0d want 0/0/0/0",
               bus_a.state, bus_a.reg_w, bus_a.instr_count, bus_b.instr_count);
    end
    cnt = 0;
    release_reset();
    repeat (5) run_instr(2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), -1);
    total++;
    if (bus_b.instr_count !== 2'd1 || bus_a.instr_count !== 16'd5) begin
      bad++;
      $display("[TB] FAIL wrap got cntw=%0d cnt=%0d want cntw=1 cnt=5",
               bus_b.instr_count, bus_a.instr_count);
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL mid_reset_wrap cycle%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    repeat (60) run_instr(2'($urandom), 1'($urandom), 1'($urandom), -1);
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL random cycle%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

`ifdef MEM_HANDSHAKE_EN
  task automatic test_handshake();
    int c0;
    c0 = cnt;
    bus_a.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      total++;
      if (bus_a.state !== 4'd1 || bus_a.ir_write !== 1'b0 || bus_a.next_pc !== 1'b0 ||
          bus_a.alu_src_b !== 2'b10) begin
        bad++;
        $display("[TB] FAIL hs_stall%0d got state=%0d ir_write=%b next_pc=%b srcb=%b want 1/0/0/10",
                 i, bus_a.state, bus_a.ir_write, bus_a.next_pc, bus_a.alu_src_b);
      end
      @(posedge clk);
      #1;
    end
    bus_a.mem_ready = 1'b1;
    #1;
    total++;
    if (bus_a.state !== 4'd1 || bus_a.ir_write !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hs_pulse got state=%0d ir_write=%b want 1/1", bus_a.state, bus_a.ir_write);
    end
    @(posedge clk);
    #1;
    bus_a.op = 2'b11;
    #1;
    total++;
    if (bus_a.state !== 4'd2 || bus_a.ir_write !== 1'b0 || bus_a.illegal !== 1'b1) begin
      bad++;
      $display("[TB] FAIL hs_decode got state=%0d ir_write=%b ill=%b want 2/0/1",
               bus_a.state, bus_a.ir_write, bus_a.illegal);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus_a.state !== 4'd1 || bus_a.instr_count !== 16'(c0)) begin
      bad++;
      $display("[TB] FAIL hs_return got state=%0d cnt=%0d want 1/%0d", bus_a.state, bus_a.instr_count, c0);
    end
  endtask
`endif

  initial begin
    bus_a.op      = 2'b00;
    bus_a.funct_i = 1'b0;
    bus_a.funct_l = 1'b0;
`ifdef MEM_HANDSHAKE_EN
    bus_a.mem_ready = 1'b1;
`endif
    test_reset();
    test_ldr_str_dp();
    test_branch_illegal();
    test_mid_reset_wrap();
    test_random();
`ifdef MEM_HANDSHAKE_EN
    test_handshake();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
